// File: rtl/counter_ctrl.sv
// counter_ctrl: start/stop/pause tick counter with one-shot or periodic reload.
// Define COUNTER_CTRL_PRESCALE_EN to divide the count tick by PRESCALE clk cycles.
module counter_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] wraps
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] period_q;
  logic             mode_q;
  logic [WIDTH-1:0] value_nxt;
  logic [WIDTH-1:0] wraps_nxt;
  logic             done_nxt;
  logic             start_ok;
  logic             abort;
  logic             load;
  logic             active;
  logic             tick;
  logic             terminal;

  if (PRESCALE < 1) begin : g_prescale_check
    $error("counter_ctrl: PRESCALE must be at least 1");
  end

  assign busy     = (state != IDLE);
  assign start_ok = start && (period != '0);
  assign abort    = stop && busy;
  assign load     = start_ok && !abort;
  // Leaving PAUSED counts on the same edge, so a pause delays done by exactly its length.
  assign active   = busy && !pause;
  assign terminal = (value == (period_q - WIDTH'(1)));

`ifdef COUNTER_CTRL_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] presc;

  assign tick = active && (presc == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (abort) begin
      presc <= presc;
    end else if (load) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else if (active) begin
      presc <= presc + PW'(1);
    end else begin
      presc <= presc;
    end
  end
`else
  assign tick = active;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      value    <= '0;
      wraps    <= '0;
      done     <= 1'b0;
      period_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      value <= value_nxt;
      wraps <= wraps_nxt;
      done  <= done_nxt;
      if (load) begin
        period_q <= period;
        mode_q   <= mode;
      end else begin
        period_q <= period_q;
        mode_q   <= mode_q;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else if (start_ok) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN, PAUSED: begin
          if (pause) begin
            state_nxt = PAUSED;
          end else if (tick && terminal && !mode_q) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    value_nxt = value;
    wraps_nxt = wraps;
    done_nxt  = 1'b0;
    if (abort) begin
      value_nxt = '0;
    end else if (start_ok) begin
      value_nxt = '0;
      wraps_nxt = '0;
    end else if (tick) begin
      if (terminal) begin
        value_nxt = '0;
        done_nxt  = 1'b1;
        if (wraps != {WIDTH{1'b1}}) begin
          wraps_nxt = wraps + WIDTH'(1);
        end else begin
          wraps_nxt = wraps;
        end
      end else begin
        value_nxt = value + WIDTH'(1);
      end
    end else begin
      value_nxt = value;
    end
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, width of period, value and wraps.
REQ-002 Parameter PRESCALE, default 4, clk cycles per count tick; used only when COUNTER_CTRL_PRESCALE_EN is defined.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request: latch period and begin counting.
REQ-006 stop  input  1  abort counting, return to IDLE.
REQ-007 pause  input  1  level: freeze counting while high.
REQ-008 mode  input  1  0 = one-shot, 1 = periodic (auto-reload); sampled with start.
REQ-009 period  input  WIDTH  terminal count P, sampled with start.
REQ-010 value  output  WIDTH  current count, registered.
REQ-011 busy  output  1  high when state is not IDLE.
REQ-012 done  output  1  one-cycle pulse per terminal-count event, registered.
REQ-013 wraps  output  WIDTH  terminal events since last start, saturating at all-ones.

Function
REQ-014 FSM states IDLE, RUN, PAUSED; busy = (state != IDLE).
REQ-015 Priority per cycle: stop > start > pause > count.
REQ-016 IDLE + start with period != 0: latch period_q and mode_q; value <= 0; wraps <= 0; go to RUN.
REQ-017 start with period == 0: ignored in every state, no output change.
REQ-018 RUN: on each count tick, value increments by 1.
REQ-019 Terminal: tick with value == period_q-1 -> value <= 0, done <= 1 on the same edge, wraps increments (saturates at 2^WIDTH-1).
REQ-020 Terminal with mode_q = 0 -> IDLE on the same edge; mode_q = 1 -> remain RUN.
REQ-021 Latency: start sampled at edge N -> busy = 1 after N; one-shot done visible after edge N+P (no prescale).
REQ-022 RUN + pause -> PAUSED; value and prescaler hold; PAUSED + pause low -> RUN, counting resumes next tick.
REQ-023 start in RUN or PAUSED: restart as in REQ-016 (relatch period/mode, clear value and wraps); no done pulse.
REQ-024 stop in RUN or PAUSED: -> IDLE, value <= 0, wraps holds, no done pulse; stop in IDLE: no effect.
REQ-025 stop coincident with terminal count: stop wins, no done, wraps unchanged.
REQ-026 period input changes while busy are ignored until the next start.
REQ-027 done is low in every cycle not directly following a terminal event.

Reset
REQ-028 reset high at an edge -> state IDLE, value 0, busy 0, done 0, wraps 0, period_q 0, mode_q 0, prescaler 0.
REQ-029 reset overrides stop, start, pause and terminal count in the same cycle, including mid-run.
REQ-030 No output leaves its reset value before the first edge with reset low.

Configuration
REQ-031 Macro COUNTER_CTRL_PRESCALE_EN defined: count tick asserted once every PRESCALE clk cycles in RUN; prescaler cleared on start, held in PAUSED and IDLE.
REQ-032 Macro undefined: count tick asserted every RUN cycle; no prescaler logic; PRESCALE unused.
REQ-033 All other behaviour is identical in both builds.

Verification
REQ-034 reset high 2 cycles, then low -> value=0, busy=0, done=0, wraps=0; no change without start.
REQ-035 period=5, mode=0, 1-cycle start -> value 0,1,2,3,4,0; done high exactly 5 cycles after start; busy falls on the same edge; wraps=1.
REQ-036 period=3, mode=1, run 12 cycles -> done every 3rd cycle, wraps=4; then stop -> value=0, busy=0, no done.
REQ-037 period=8 one-shot, pause held 4 cycles at value=2 -> value holds 2, state PAUSED, done delayed by exactly 4 cycles.
REQ-038 Terminal cycle with stop asserted -> no done, IDLE; start with period=0 -> busy stays 0; reset at value=7 -> all outputs 0 after next edge.
REQ-039 With COUNTER_CTRL_PRESCALE_EN, PRESCALE=4, period=3 one-shot -> value steps every 4 cycles, done 12 cycles after start.
